// File: rtl/culsans_ila_pkg.sv
// Shared types and helpers for the ACE snoop ILA monitor.
// Covers the trigger FSM encoding, the probe bundle layout and saturating arithmetic.
package culsans_ila_pkg;

  typedef enum logic [1:0] {
    ARMED     = 2'd0,
    TRIGGERED = 2'd1,
    FROZEN    = 2'd2
  } ila_state_e;

  typedef struct packed {
    logic [47:0]      addr;  // probe12
    logic [11:0][31:0] p;    // probe0..probe11
  } ila_probes_t;

  localparam int CR_DT_BIT = 0;

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage

// File: rtl/ace_snoop_ila_monitor_if.sv
// Observation bundle for one ACE snoop port (AC request, CR response, CD data channels).
// The monitor only ever sees it through the slave modport, so it can never drive a handshake.
interface ace_snoop_ila_monitor_if #(
  parameter int unsigned AddrWidth = 48
);
  logic                 ac_valid;
  logic                 ac_ready;
  logic [AddrWidth-1:0] ac_addr;
  logic [3:0]           ac_snoop;
  logic                 cr_valid;
  logic                 cr_ready;
  logic [4:0]           cr_resp;
  logic                 cd_valid;
  logic                 cd_ready;
  logic                 cd_last;

  modport master (
    output ac_valid, ac_ready, ac_addr, ac_snoop,
    output cr_valid, cr_ready, cr_resp,
    output cd_valid, cd_ready, cd_last
  );

  modport slave (
    input ac_valid, ac_ready, ac_addr, ac_snoop,
    input cr_valid, cr_ready, cr_resp,
    input cd_valid, cd_ready, cd_last
  );
endinterface

// File: rtl/snoop_ts_fifo.sv
// Timestamp FIFO pairing each accepted AC with its later CR.
// Head is read combinationally so the pop cycle can compute latency; push+pop when full is legal.
module snoop_ts_fifo #(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [Width-1:0]         data_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   usage_o
);
  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW:0]    wr_ptr_q, wr_ptr_d;
  logic [PtrW:0]    rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                   (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  assign usage_o = wr_ptr_q - rd_ptr_q;
  assign data_o  = mem_q[rd_ptr_q[PtrW-1:0]];

  // A pop frees the head slot in the same cycle, so a full FIFO can accept a push alongside it.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{PtrW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{PtrW{1'b0}}, do_pop};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !rst_i) begin
      mem_q[wr_ptr_q[PtrW-1:0]] <= data_i;
    end
  end
endmodule

// File: rtl/ace_snoop_ila_monitor.sv
// Passive ACE snoop-port monitor feeding the ILA probes: traffic counters, CR latency stats,
// and a trigger FSM that freezes every probe a fixed number of cycles after a latency violation.
module ace_snoop_ila_monitor
  import culsans_ila_pkg::*;
#(
  parameter int unsigned AddrWidth  = 48,
  parameter int unsigned MaxOutstd  = 8,
  parameter int unsigned LatThresh  = 256,
  parameter int unsigned HoldCycles = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  freeze_i,
  ace_snoop_ila_monitor_if.slave snp,
  output logic [31:0]           probe0_o,
  output logic [31:0]           probe1_o,
  output logic [31:0]           probe2_o,
  output logic [31:0]           probe3_o,
  output logic [31:0]           probe4_o,
  output logic [31:0]           probe5_o,
  output logic [31:0]           probe6_o,
  output logic [31:0]           probe7_o,
  output logic [31:0]           probe8_o,
  output logic [31:0]           probe9_o,
  output logic [31:0]           probe10_o,
  output logic [31:0]           probe11_o,
  output logic [47:0]           probe12_o
);
  localparam int unsigned UsageW = $clog2(MaxOutstd) + 1;

  ila_state_e state_q, state_d;
  logic [31:0] hold_q, hold_d;
  logic [31:0] cyc_cnt_q, cyc_cnt_d;
  logic [31:0] ac_cnt_q, ac_cnt_d, cr_cnt_q, cr_cnt_d, cd_cnt_q, cd_cnt_d;
  logic [31:0] cd_last_cnt_q, cd_last_cnt_d, occ_q, occ_d;
  logic [31:0] lat_q, lat_d, lat_max_q, lat_max_d, lat_sum_q, lat_sum_d;
  logic [31:0] cyc_out_q, cyc_out_d, dt_cnt_q, dt_cnt_d, err_cnt_q, err_cnt_d;
  logic [11:0] info_q, info_d;
  logic [47:0] addr_q, addr_d;

  logic [AddrWidth-1:0] ac_addr;
  logic                 live, ac_ev, cr_ev, cd_ev;
  logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [31:0]          fifo_ts, lat;
  logic [UsageW-1:0]    fifo_usage;
  ila_probes_t          probes;

  assign ac_addr = snp.ac_addr;

  // Nothing is observed while frozen, either by the FSM or by the manual freeze input.
  assign live  = (state_q != FROZEN) && !freeze_i;
  assign ac_ev = snp.ac_valid & snp.ac_ready & live;
  assign cr_ev = snp.cr_valid & snp.cr_ready & live;
  assign cd_ev = snp.cd_valid & snp.cd_ready & live;

  // Pop is decided on the pre-cycle state; a same-cycle pop makes room for the push.
  assign fifo_pop  = cr_ev & ~fifo_empty;
  assign fifo_push = ac_ev & (~fifo_full | fifo_pop);
  assign lat       = cyc_cnt_q - fifo_ts;

  snoop_ts_fifo #(
    .Depth (MaxOutstd),
    .Width (32)
  ) u_ts_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i | clear_i),
    .push_i  (fifo_push),
    .data_i  (cyc_cnt_q),
    .pop_i   (fifo_pop),
    .data_o  (fifo_ts),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .usage_o (fifo_usage)
  );

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    unique case (state_q)
      ARMED: begin
        if (fifo_pop && (lat > LatThresh)) begin
          state_d = TRIGGERED;
          hold_d  = HoldCycles;
        end
      end
      TRIGGERED: begin
        if (hold_q <= 32'd1) begin
          hold_d  = '0;
          state_d = FROZEN;
        end else begin
          hold_d = hold_q - 32'd1;
        end
      end
      FROZEN:  state_d = FROZEN;
      default: state_d = ARMED;
    endcase
    if (clear_i) begin
      state_d = ARMED;
      hold_d  = '0;
    end
  end

  always_comb begin
    cyc_cnt_d     = cyc_cnt_q + 32'd1;
    ac_cnt_d      = ac_cnt_q;
    cr_cnt_d      = cr_cnt_q;
    cd_cnt_d      = cd_cnt_q;
    cd_last_cnt_d = cd_last_cnt_q;
    occ_d         = 32'(fifo_usage) + 32'(fifo_push) - 32'(fifo_pop);
    lat_d         = lat_q;
    lat_max_d     = lat_max_q;
    lat_sum_d     = lat_sum_q;
    cyc_out_d     = cyc_out_q;
    dt_cnt_d      = dt_cnt_q;
    err_cnt_d     = err_cnt_q;
    addr_d        = addr_q;
    info_d        = info_q;
    info_d[11]    = freeze_i;

    if (live) begin
      cyc_out_d     = cyc_cnt_d;
      info_d[10:9]  = state_d;
    end
    if (ac_ev) begin
      ac_cnt_d     = ac_cnt_q + 32'd1;
      addr_d       = 48'(ac_addr);
      info_d[3:0]  = snp.ac_snoop;
    end
    if (cr_ev) begin
      cr_cnt_d    = cr_cnt_q + 32'd1;
      info_d[8:4] = snp.cr_resp;
      if (snp.cr_resp[CR_DT_BIT]) dt_cnt_d = dt_cnt_q + 32'd1;
    end
    if (cd_ev) begin
      cd_cnt_d = cd_cnt_q + 32'd1;
      if (snp.cd_last) cd_last_cnt_d = cd_last_cnt_q + 32'd1;
    end
    if (fifo_pop) begin
      lat_d     = lat;
      lat_max_d = (lat > lat_max_q) ? lat : lat_max_q;
      lat_sum_d = sat_add32(lat_sum_q, lat);
    end
    if ((cr_ev && fifo_empty) || (ac_ev && fifo_full && !cr_ev)) begin
      err_cnt_d = err_cnt_q + 32'd1;
    end

    // Clear wipes everything the probes show except the free-running cycle count.
    if (clear_i) begin
      ac_cnt_d      = '0;
      cr_cnt_d      = '0;
      cd_cnt_d      = '0;
      cd_last_cnt_d = '0;
      occ_d         = '0;
      lat_d         = '0;
      lat_max_d     = '0;
      lat_sum_d     = '0;
      dt_cnt_d      = '0;
      err_cnt_d     = '0;
      addr_d        = '0;
      info_d        = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ARMED;
      hold_q        <= '0;
      cyc_cnt_q     <= '0;
      ac_cnt_q      <= '0;
      cr_cnt_q      <= '0;
      cd_cnt_q      <= '0;
      cd_last_cnt_q <= '0;
      occ_q         <= '0;
      lat_q         <= '0;
      lat_max_q     <= '0;
      lat_sum_q     <= '0;
      cyc_out_q     <= '0;
      dt_cnt_q      <= '0;
      err_cnt_q     <= '0;
      addr_q        <= '0;
      info_q        <= '0;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      cyc_cnt_q     <= cyc_cnt_d;
      ac_cnt_q      <= ac_cnt_d;
      cr_cnt_q      <= cr_cnt_d;
      cd_cnt_q      <= cd_cnt_d;
      cd_last_cnt_q <= cd_last_cnt_d;
      occ_q         <= occ_d;
      lat_q         <= lat_d;
      lat_max_q     <= lat_max_d;
      lat_sum_q     <= lat_sum_d;
      cyc_out_q     <= cyc_out_d;
      dt_cnt_q      <= dt_cnt_d;
      err_cnt_q     <= err_cnt_d;
      addr_q        <= addr_d;
      info_q        <= info_d;
    end
  end

  always_comb begin
    probes.p[0]  = ac_cnt_q;
    probes.p[1]  = cr_cnt_q;
    probes.p[2]  = cd_cnt_q;
    probes.p[3]  = cd_last_cnt_q;
    probes.p[4]  = occ_q;
    probes.p[5]  = lat_q;
    probes.p[6]  = lat_max_q;
    probes.p[7]  = lat_sum_q;
    probes.p[8]  = cyc_out_q;
    probes.p[9]  = dt_cnt_q;
    probes.p[10] = {20'd0, info_q};
    probes.p[11] = err_cnt_q;
    probes.addr  = addr_q;
  end

  assign probe0_o  = probes.p[0];
  assign probe1_o  = probes.p[1];
  assign probe2_o  = probes.p[2];
  assign probe3_o  = probes.p[3];
  assign probe4_o  = probes.p[4];
  assign probe5_o  = probes.p[5];
  assign probe6_o  = probes.p[6];
  assign probe7_o  = probes.p[7];
  assign probe8_o  = probes.p[8];
  assign probe9_o  = probes.p[9];
  assign probe10_o = probes.p[10];
  assign probe11_o = probes.p[11];
  assign probe12_o = probes.addr;
endmodule
